// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared types and widths for the sum-of-products sequencer
package mac_seq_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int SUM_W  = 17;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE_AB = 2'd1,
        ST_ISSUE_CD = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [1:0] WR_SEL_A = 2'd0;
    localparam logic [1:0] WR_SEL_B = 2'd1;
    localparam logic [1:0] WR_SEL_C = 2'd2;
    localparam logic [1:0] WR_SEL_D = 2'd3;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge event from a level; history resets high so a held level never fires
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic event_o
);

    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= level_i;
        end
    end

    assign event_o = level_i & ~hist_q;

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - a*b + c*d over one shared external multiplier in two passes
// Optional MAC_SAT_EN: saturate result to 0xFFFF when the 17-bit sum overflows.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_req,
    input  logic [1:0]          wr_sel,
    input  logic [OP_W-1:0]     wr_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [PROD_W-1:0]   result,
    output logic                ovf,
    output logic [OP_W-1:0]     mul_a,
    output logic [OP_W-1:0]     mul_b,
    input  logic [PROD_W-1:0]   mul_p
);

    localparam logic [1:0] LAT_CNT = 2'(MUL_LAT);

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [SUM_W-1:0]    acc_q, acc_d;
    logic [PROD_W-1:0]   result_q, result_d;
    logic                ovf_q, ovf_d;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [SUM_W-1:0]    sum;
    logic                wr_evt, start_evt;

    rise_detect u_wr_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (wr_req),
        .event_o (wr_evt)
    );

    rise_detect u_start_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (start),
        .event_o (start_evt)
    );

    assign sum = acc_q + {1'b0, mul_p};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        mul_a    = '0;
        mul_b    = '0;
        busy     = 1'b1;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                // A write and start in the same cycle both land on the entering edge
                if (wr_evt) begin
                    case (wr_sel)
                        WR_SEL_A: a_d = wr_data;
                        WR_SEL_B: b_d = wr_data;
                        WR_SEL_C: c_d = wr_data;
                        default:  d_d = wr_data;
                    endcase
                end
                if (start_evt) begin
                    state_d = ST_ISSUE_AB;
                    cnt_d   = LAT_CNT;
                end
            end
            ST_ISSUE_AB: begin
                mul_a = a_q;
                mul_b = b_q;
                if (cnt_q == 2'd0) begin
                    acc_d   = {1'b0, mul_p};
                    cnt_d   = LAT_CNT;
                    state_d = ST_ISSUE_CD;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_ISSUE_CD: begin
                mul_a = c_q;
                mul_b = d_q;
                if (cnt_q == 2'd0) begin
`ifdef MAC_SAT_EN
                    result_d = sum[SUM_W-1] ? {PROD_W{1'b1}} : sum[PROD_W-1:0];
`else
                    result_d = sum[PROD_W-1:0];
`endif
                    ovf_d   = sum[SUM_W-1];
                    cnt_d   = 2'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - directed self-checking bench for mac_sequencer with a one-cycle multiplier model
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req;
    logic [1:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic [15:0] p_q;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) p_q <= 16'(mul_a) * 16'(mul_b);
    assign mul_p = p_q;

    mac_sequencer #(.MUL_LAT(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_req  (wr_req),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_p   (mul_p)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_op(input logic [1:0] sel, input logic [7:0] val);
        wr_sel  = sel;
        wr_data = val;
        wr_req  = 1'b1;
        step();
        wr_req  = 1'b0;
        step();
    endtask

    // start (and optionally wr_req) must already be high; the next edge is edge 0
    task automatic run_check(input string tag, input logic [7:0] exp_mul_a1,
                             input logic [15:0] exp_res, input logic exp_ovf);
        logic [15:0] res_before;
        res_before = result;
        step();
        start  = 1'b0;
        wr_req = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_done"}, 32'(done), (cyc == 5) ? 32'd1 : 32'd0);
            if (cyc == 1) chk({tag, "_mul_a_c1"}, 32'(mul_a), 32'(exp_mul_a1));
            if (cyc == 4) chk({tag, "_result_hold"}, 32'(result), 32'(res_before));
        end
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        @(negedge clk);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_done_end"}, 32'(done), 32'd0);
        chk({tag, "_mul_a_idle"}, 32'(mul_a), 32'd0);
    endtask

    logic [15:0] exp_max;
    int          seen;

    initial begin
`ifdef MAC_SAT_EN
        exp_max = 16'hFFFF;
`else
        exp_max = 16'hFC02;
`endif
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        wr_sel  = 2'd0;
        wr_data = 8'd0;
        start   = 1'b1;

        // reset release with start held high must not trigger
        #23;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        chk("rst_hold_no_busy_done", 32'(seen), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        step();
        start = 1'b0;
        step();

        write_op(2'd0, 8'd3);
        write_op(2'd1, 8'd4);
        write_op(2'd2, 8'd5);
        write_op(2'd3, 8'd6);
        start = 1'b1;
        run_check("basic", 8'd3, 16'h002A, 1'b0);

        write_op(2'd0, 8'd255);
        write_op(2'd1, 8'd255);
        write_op(2'd2, 8'd255);
        write_op(2'd3, 8'd255);
        start = 1'b1;
        run_check("max", 8'd255, exp_max, 1'b1);

        // write c=9 while busy must be dropped
        start = 1'b1;
        step();
        start   = 1'b0;
        wr_sel  = 2'd2;
        wr_data = 8'd9;
        wr_req  = 1'b1;
        step();
        wr_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("busywr_done_seen", 32'(seen), 32'd1);
        chk("busywr_result", 32'(result), 32'(exp_max));
        step();
        start = 1'b1;
        run_check("busywr_rerun", 8'd255, exp_max, 1'b1);

        write_op(2'd1, 8'd10);
        write_op(2'd2, 8'd0);
        write_op(2'd3, 8'd0);
        wr_sel  = 2'd0;
        wr_data = 8'd2;
        wr_req  = 1'b1;
        start   = 1'b1;
        run_check("same_cycle", 8'd2, 16'h0014, 1'b0);

        // abort mid ISSUE_CD with asynchronous reset
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("abort_in_cd_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_mul_b", 32'(mul_b), 32'd0);
        #12;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        step();
        start = 1'b1;
        run_check("post_abort", 8'd0, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
